// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold a floor index 0..num_floors-1 (at least one bit).
    function automatic int floor_width(input int num_floors);
        return (num_floors <= 2) ? 1 : $clog2(num_floors);
    endfunction

    // Bits needed for a down-counter that is loaded with max_count.
    function automatic int count_width(input int max_count);
        return (max_count <= 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/door_dwell_timer.sv
// Door dwell down-counter: load/restart to TICKS, counts down only while
// enabled, flags the last open cycle.
module door_dwell_timer
    import elevator_pkg::*;
#(
    parameter int TICKS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable_i,
    input  logic load_i,
    output logic expire_o
);

    localparam int CW = count_width(TICKS);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TICKS);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load wins over counting; the counter parks at zero once it runs out.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == ONE);

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator car controller: latches floor calls, SCAN direction choice,
// floor-by-floor travel timing and door dwell.
// Optional build macro ELEVATOR_FIRE_RECALL_EN adds the fire_recall input
// (car returns to floor 0 and holds the door open while recall is active).
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | stopped, door closed, choosing the next action
// MOVING    | motor on, travel counter timing one floor step
// DOOR_OPEN | stopped at a floor, door open, dwell timer running
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 4,
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_FLOORS-1:0]               call_req,
    input  logic                                door_sensor,
    input  logic                                door_hold,
`ifdef ELEVATOR_FIRE_RECALL_EN
    input  logic                                fire_recall,
`endif
    output logic [floor_width(NUM_FLOORS)-1:0]  floor,
    output logic                                moving,
    output logic                                dir_up,
    output logic                                door_open,
    output logic [NUM_FLOORS-1:0]               pending
);

    localparam int FW = floor_width(NUM_FLOORS);
    localparam int TW = count_width(TRAVEL_TICKS);
    localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);
    localparam logic [FW-1:0] FLOOR_ONE   = FW'(1);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_TICKS);
    localparam logic [TW-1:0] TRAVEL_ONE  = TW'(1);

    state_e                  state_q, state_d;
    logic [FW-1:0]           floor_q, floor_d;
    logic                    dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [TW-1:0]           travel_q, travel_d;

    logic                    recall;
    logic [NUM_FLOORS-1:0]   pend_m;
    logic [NUM_FLOORS-1:0]   served;
    logic                    above, below;
    logic                    at_bound;
    logic [FW-1:0]           step_floor;
    logic                    step_at_end;
    logic                    restart;
    logic                    dwell_load, dwell_en, dwell_expire;

`ifdef ELEVATOR_FIRE_RECALL_EN
    assign recall = fire_recall;
`else
    assign recall = 1'b0;
`endif

    // Calls seen this cycle count immediately; recall discards all calls.
    assign pend_m    = recall ? '0 : (pending_q | call_req);
    assign pending_d = pend_m & ~served;

    // Sensor, hold and a call at this floor only matter while the door is open.
    assign restart = ~recall & (door_sensor | door_hold | call_req[floor_q]);

    // End-of-shaft guard: the next step is clamped so the floor never leaves range.
    assign at_bound    = dir_up_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
    assign step_floor  = at_bound ? floor_q
                       : (dir_up_q ? floor_q + FLOOR_ONE : floor_q - FLOOR_ONE);
    assign step_at_end = dir_up_q ? (step_floor == TOP_FLOOR) : (step_floor == '0);

    // Any pending call above or below the current floor.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend_m[i] && (FW'(i) > floor_q)) above = 1'b1;
            if (pend_m[i] && (FW'(i) < floor_q)) below = 1'b1;
        end
    end

    assign dwell_en = (state_q == DOOR_OPEN);

    door_dwell_timer #(
        .TICKS    (DOOR_TICKS)
    ) u_dwell (
        .clock    (clock),
        .reset    (reset),
        .enable_i (dwell_en),
        .load_i   (dwell_load),
        .expire_o (dwell_expire)
    );

    // State register together with the car datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_up_q  <= DIR_UP;
            pending_q <= '0;
            travel_q  <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
            travel_q  <= travel_d;
        end
    end

    // Next-state logic: SCAN decision, floor stepping and door handling.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        travel_d   = travel_q;
        served     = '0;
        dwell_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (recall) begin
                    if (floor_q == '0) begin
                        state_d    = DOOR_OPEN;
                        dwell_load = 1'b1;
                    end else begin
                        state_d  = MOVING;
                        dir_up_d = DIR_DOWN;
                        travel_d = TRAVEL_LOAD;
                    end
                end else if (pend_m[floor_q]) begin
                    served[floor_q] = 1'b1;
                    state_d         = DOOR_OPEN;
                    dwell_load      = 1'b1;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = MOVING;
                    dir_up_d = DIR_UP;
                    travel_d = TRAVEL_LOAD;
                end else if (below) begin
                    state_d  = MOVING;
                    dir_up_d = DIR_DOWN;
                    travel_d = TRAVEL_LOAD;
                end
            end
            MOVING: begin
                if (travel_q == TRAVEL_ONE) begin
                    floor_d  = step_floor;
                    travel_d = TRAVEL_LOAD;
                    if (recall) begin
                        if (step_floor == '0) begin
                            state_d    = DOOR_OPEN;
                            dwell_load = 1'b1;
                            travel_d   = '0;
                        end else begin
                            dir_up_d = DIR_DOWN;
                        end
                    end else if (pend_m[step_floor]) begin
                        served[step_floor] = 1'b1;
                        state_d            = DOOR_OPEN;
                        dwell_load         = 1'b1;
                        travel_d           = '0;
                    end else if (step_at_end) begin
                        // Only reachable if the target call vanished (recall); stop here.
                        state_d  = IDLE;
                        travel_d = '0;
                    end
                end else begin
                    travel_d = travel_q - TRAVEL_ONE;
                end
            end
            DOOR_OPEN: begin
                if (recall) begin
                    if (floor_q == '0) begin
                        dwell_load = 1'b1;
                    end else begin
                        state_d  = MOVING;
                        dir_up_d = DIR_DOWN;
                        travel_d = TRAVEL_LOAD;
                    end
                end else if (restart) begin
                    served[floor_q] = call_req[floor_q];
                    dwell_load      = 1'b1;
                end else if (dwell_expire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode straight from the registered state.
    always_comb begin
        moving    = (state_q == MOVING);
        door_open = (state_q == DOOR_OPEN);
        floor     = floor_q;
        dir_up    = dir_up_q;
        pending   = pending_q;
    end

    // A floor step must never be requested past either end of the shaft.
    step_in_range: assert property (@(posedge clock) disable iff (reset)
        ((state_q == MOVING) && (travel_q == TRAVEL_ONE)) |-> !at_bound);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler (default build, 4 floors,
// 3-cycle travel, 4-cycle dwell). Expected output words are queued as each
// cycle's stimulus is applied and compared at the following falling edge.
module tb_elevator_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] call_req;
    logic       door_sensor;
    logic       door_hold;
    logic [1:0] floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } exp_t;

    exp_t sb[$];

    elevator_scheduler #(
        .NUM_FLOORS   (4),
        .TRAVEL_TICKS (3),
        .DOOR_TICKS   (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .call_req    (call_req),
        .door_sensor (door_sensor),
        .door_hold   (door_hold),
        .floor       (floor),
        .moving      (moving),
        .dir_up      (dir_up),
        .door_open   (door_open),
        .pending     (pending)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] pk(input int fl, input int mv, input int up,
                                      input int dr, input int pd);
        return {2'(fl), 1'(mv), 1'(up), 1'(dr), 4'(pd)};
    endfunction

    function automatic logic [8:0] observed();
        return {floor, moving, dir_up, door_open, pending};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed fl/mv/up/dr/pend=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Hold the inputs for n cycles; each cycle's outputs must equal the expected word.
    task automatic cyc(input int n, input int call, input int sen, input int hld,
                       input int fl, input int mv, input int up, input int dr,
                       input int pd, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            call_req    = 4'(call);
            door_sensor = 1'(sen);
            door_hold   = 1'(hld);
            sb.push_back('{tag, pk(fl, mv, up, dr, pd)});
            @(posedge clock);
            @(negedge clock);
            e = sb.pop_front();
            check(e.tag, observed(), e.exp);
        end
        call_req    = '0;
        door_sensor = 1'b0;
        door_hold   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        call_req    = '0;
        door_sensor = 1'b0;
        door_hold   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_values", observed(), pk(0, 0, 1, 0, 0));
        reset = 1'b0;

        // Call to top floor: 3 cycles per floor, door 4 cycles, back to idle.
        cyc(1, 'b1000, 0, 0, 0, 1, 1, 0, 'b1000, "start_up");
        cyc(2, 0,      0, 0, 0, 1, 1, 0, 'b1000, "travel_f0");
        cyc(3, 0,      0, 0, 1, 1, 1, 0, 'b1000, "travel_f1");
        cyc(3, 0,      0, 0, 2, 1, 1, 0, 'b1000, "travel_f2");
        cyc(4, 0,      0, 0, 3, 0, 1, 1, 'b0000, "dwell_f3");
        cyc(1, 0,      0, 0, 3, 0, 1, 0, 'b0000, "idle_f3");

        // Call at the floor the car is idling on.
        cyc(1, 'b1000, 0, 0, 3, 0, 1, 1, 'b0000, "same_floor_open");
        cyc(3, 0,      0, 0, 3, 0, 1, 1, 'b0000, "same_floor_dwell");
        cyc(1, 0,      0, 0, 3, 0, 1, 0, 'b0000, "same_floor_close");

        // Hold ignored while moving; sensor on the last dwell cycle extends by 4.
        cyc(1, 'b0100, 0, 0, 3, 1, 0, 0, 'b0100, "start_dn");
        cyc(2, 0,      0, 1, 3, 1, 0, 0, 'b0100, "hold_while_moving");
        cyc(1, 0,      0, 1, 2, 0, 0, 1, 'b0000, "arrive_f2");
        cyc(3, 0,      0, 0, 2, 0, 0, 1, 'b0000, "dwell_f2");
        cyc(1, 0,      1, 0, 2, 0, 0, 1, 'b0000, "sensor_restart");
        cyc(3, 0,      0, 0, 2, 0, 0, 1, 'b0000, "dwell_extended");
        cyc(1, 0,      0, 0, 2, 0, 0, 0, 'b0000, "close_f2");

        // Calls above and below while heading down: down keeps priority.
        cyc(1, 'b1001, 0, 0, 2, 1, 0, 0, 'b1001, "scan_keep_dn");
        cyc(2, 0,      0, 0, 2, 1, 0, 0, 'b1001, "travel_f2_dn");
        cyc(3, 0,      0, 0, 1, 1, 0, 0, 'b1001, "travel_f1_dn");
        cyc(1, 0,      0, 0, 0, 0, 0, 1, 'b1000, "arrive_f0");
        cyc(3, 0,      0, 0, 0, 0, 0, 1, 'b1000, "dwell_f0");
        cyc(1, 0,      0, 0, 0, 0, 0, 0, 'b1000, "idle_f0");
        cyc(1, 0,      0, 0, 0, 1, 1, 0, 'b1000, "reverse_up");
        cyc(2, 0,      0, 0, 0, 1, 1, 0, 'b1000, "travel_f0_up");

        // Call for a floor already passed stays pending for the return sweep.
        cyc(1, 0,      0, 0, 1, 1, 1, 0, 'b1000, "travel_f1_up");
        cyc(1, 'b0001, 0, 0, 1, 1, 1, 0, 'b1001, "passed_call");
        cyc(1, 0,      0, 0, 1, 1, 1, 0, 'b1001, "passed_kept");
        cyc(3, 0,      0, 0, 2, 1, 1, 0, 'b1001, "travel_f2_up");
        cyc(1, 0,      0, 0, 3, 0, 1, 1, 'b0001, "arrive_f3");
        cyc(3, 0,      0, 0, 3, 0, 1, 1, 'b0001, "dwell_f3b");
        cyc(1, 0,      0, 0, 3, 0, 1, 0, 'b0001, "idle_f3b");
        cyc(1, 0,      0, 0, 3, 1, 0, 0, 'b0001, "reverse_dn");
        cyc(2, 0,      0, 0, 3, 1, 0, 0, 'b0001, "travel_f3_dn");

        // Call for floor 2 arriving in the very step cycle into floor 2.
        cyc(1, 'b0100, 0, 0, 2, 0, 0, 1, 'b0001, "late_call_stop");
        cyc(3, 0,      0, 0, 2, 0, 0, 1, 'b0001, "dwell_f2b");
        cyc(1, 0,      0, 0, 2, 0, 0, 0, 'b0001, "idle_f2b");
        cyc(1, 0,      0, 0, 2, 1, 0, 0, 'b0001, "resume_dn");
        cyc(2, 0,      0, 0, 2, 1, 0, 0, 'b0001, "travel_f2_dn2");
        cyc(3, 0,      0, 0, 1, 1, 0, 0, 'b0001, "travel_f1_dn2");
        cyc(1, 0,      0, 0, 0, 0, 0, 1, 'b0000, "arrive_f0b");
        cyc(3, 0,      0, 0, 0, 0, 0, 1, 'b0000, "dwell_f0b");
        cyc(1, 0,      0, 0, 0, 0, 0, 0, 'b0000, "idle_f0b");

        // Own-floor call at floor 0: door only, no motion.
        cyc(1, 'b0001, 0, 0, 0, 0, 0, 1, 'b0000, "f0_call_open");
        cyc(3, 0,      0, 0, 0, 0, 0, 1, 'b0000, "f0_dwell");
        cyc(1, 0,      0, 0, 0, 0, 0, 0, 'b0000, "f0_close");

        // Only a call above while last direction was down: goes up.
        cyc(1, 'b0100, 0, 0, 0, 1, 1, 0, 'b0100, "up_nothing_below");
        cyc(2, 0,      0, 0, 0, 1, 1, 0, 'b0100, "travel_f0_up2");
        cyc(1, 0,      0, 0, 1, 1, 1, 0, 'b0100, "mid_travel_f1");

        // Asynchronous reset between clock edges while moving.
        #2 reset = 1'b1;
        #1 check("async_reset", observed(), pk(0, 0, 1, 0, 0));
        @(negedge clock);
        reset = 1'b0;
        cyc(3, 0,      0, 0, 0, 0, 1, 0, 'b0000, "post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
